bit_serial_add_ctrl: RTL and testbench

Sequencer that wraps a 1-bit full-adder cell into a parallel-in/parallel-out WIDTH-bit adder. It accepts a start request with two parallel operands and a carry-in, then shifts operand bits LSB-first into an external full-adder cell, one bit per clock. It registers the carry between cycles, collects the serial sum, and presents the result with a one-cycle done pulse. It sits between the datapath register file and the serial adder cell, so that serial addition looks like a fixed-latency parallel operation.

---
 rtl/bit_serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_add_ctrl.sv
// Sequencer that drives an external 1-bit full-adder cell LSB-first
// so a WIDTH-bit add looks like a fixed-latency parallel operation.
module bit_serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_co
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             last;

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          // carry_q here is the carry into the MSB
          sum_d   = s_sh_d;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign fa_a = a_sh_q[0];
  assign fa_b = b_sh_q[0];
  assign fa_c = carry_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Bench for bit_serial_add_ctrl: directed cases plus random adds
// checked against an integer-arithmetic reference.
module tb_bit_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cin;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  logic         fa_a, fa_b, fa_c, fa_s, fa_co;

  int vecs = 0;
  int errs = 0;

  bit_serial_add_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a_in (a_in),
    .b_in (b_in),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf),
    .fa_a (fa_a),
    .fa_b (fa_b),
    .fa_c (fa_c),
    .fa_s (fa_s),
    .fa_co(fa_co)
  );

  // external full-adder cell
  assign fa_s  = fa_a ^ fa_b ^ fa_c;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference: plain integer arithmetic
  task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, output logic [W-1:0] s,
                         output logic co, output logic ov);
    int u, sa, sb, ss;
    u  = int'(a) + int'(b) + int'(c);
    s  = W'(u);
    co = (u >= (1 << W));
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    ss = sa + sb + int'(c);
    ov = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
  endtask

  // waits for done, returns edges counted after acceptance
  task automatic wait_done(input bit chk_fac, output int n);
    n = 0;
    while (!done && n < 40) begin
      if (chk_fac) chk("fa_c_ripple", fa_c, 1);
      chk("busy_shift", busy, 1);
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c,
                        input bit chk_fac);
    logic [W-1:0] es;
    logic eco, eov;
    int n;
    ref_add(a, b, c, es, eco, eov);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    cin   = 1'($urandom);
    wait_done(chk_fac, n);
    chk({tag, "_lat"}, n, W);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, eco);
    chk({tag, "_ovf"}, ovf, eov);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold"}, sum, es);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    reset = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_fa", {fa_a, fa_b, fa_c}, 0);
    reset = 1'b1;
    tick();

    run_op("basic", 8'h31, 8'h14, 1'b1, 0);
    run_op("carry", 8'd200, 8'd100, 1'b0, 0);
    run_op("ripple", 8'hFF, 8'h00, 1'b1, 1);
    run_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 0);
    run_op("ovf_neg", 8'h80, 8'h80, 1'b0, 0);
    chk("ovf_neg_abs_sum", sum, 8'h00);

    // start during SHIFT is ignored, then held into IDLE
    a_in  = 8'h31;
    b_in  = 8'h14;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a_in  = 8'hAA;
    b_in  = 8'h55;
    cin   = 1'b0;
    start = 1'b1;
    n = 2;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("rej_lat", n, W);
    chk("rej_sum", sum, 8'h46);
    chk("rej_cout", cout, 0);
    tick();
    chk("rej_idle", busy, 0);
    tick();
    start = 1'b0;
    chk("rej_accept", busy, 1);
    wait_done(0, n);
    chk("rej2_lat", n, W);
    chk("rej2_sum", sum, 8'hFF);
    chk("rej2_cout", cout, 0);
    tick();

    // reset mid-operation
    a_in  = 8'h31;
    b_in  = 8'h14;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_sum", sum, 0);
    chk("mid_cout", cout, 0);
    chk("mid_fa", {fa_a, fa_b, fa_c}, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) n++;
      tick();
    end
    chk("mid_no_done", n, 0);
    run_op("post_rst", 8'h31, 8'h14, 1'b1, 0);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op("rnd", ra, rb, 1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
